// File: rtl/adc_capture_sequencer_if.sv
// Signal bundle between the host/FIFO side and adc_capture_sequencer.
// The master side drives the capture request, source select, ADC sample and
// FIFO back-pressure; the slave side (the sequencer) drives the FIFO write
// strobe, the converted sample and the status flags.
interface adc_capture_sequencer_if;
    logic        collectData;   // host capture request, level-sensitive
    logic        testMode;      // 1 = counter source, 0 = ADC source
    logic [9:0]  adcData;       // unsigned ADC sample, new value every clock
    logic        fifoFull;      // FIFO cannot take a write (one entry early)
    logic        fifoWrite;     // one-cycle write strobe
    logic [15:0] fifoData;      // signed 16-bit sample, valid with fifoWrite
    logic        overflow;      // sticky: a sample was dropped since last start
    logic        busy;          // sequencer is not idle

    modport master (
        output collectData,
        output testMode,
        output adcData,
        output fifoFull,
        input  fifoWrite,
        input  fifoData,
        input  overflow,
        input  busy
    );

    modport slave (
        input  collectData,
        input  testMode,
        input  adcData,
        input  fifoFull,
        output fifoWrite,
        output fifoData,
        output overflow,
        output busy
    );
endinterface

// File: rtl/adc_capture_sequencer.sv
// ADC capture sequencer.
// On a host request the block discards SETTLE_CYCLES samples while the ADC
// pipeline settles, then streams one sample per clock into a downstream FIFO
// as a signed 16-bit word. When the request drops, the block keeps streaming
// until the written word count reaches a BLOCK_WORDS boundary so the host
// always receives whole blocks. Samples offered while the FIFO is full are
// dropped and flagged through a sticky overflow bit.
module adc_capture_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int BLOCK_WORDS   = 8192
) (
    input logic                    clock,
    input logic                    reset,
    adc_capture_sequencer_if.slave bus
);

    // Word counter is exactly log2(BLOCK_WORDS) bits so it wraps on a block
    // boundary by itself.
    localparam int         WORD_CNT_W  = $clog2(BLOCK_WORDS);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    // (sample - 512) * 64 in 16-bit two's complement. Inverting the MSB turns
    // offset binary into two's complement; the six zero LSBs are the *64.
    function automatic logic [15:0] f_offset_to_signed(input logic [9:0] i_sample);
        f_offset_to_signed = {~i_sample[9], i_sample[8:0], 6'b000000};
    endfunction

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_settle_cnt;
    logic [WORD_CNT_W-1:0]   r_word_cnt;
    logic [WORD_CNT_W-1:0]   w_word_next;
    logic [9:0]              r_test_cnt;
    logic                    r_src_sel;
    logic [9:0]              r_adc_q;
    logic                    r_overflow;
    logic                    r_fifo_write;
    logic [15:0]             r_fifo_data;
    logic                    r_busy;

    logic                    w_start;
    logic                    w_offer;
    logic                    w_write;
    logic                    w_drop;
    logic [9:0]              w_sample;

    // Datapath decode: start condition, per-cycle offer/write/drop and the
    // word count this cycle's write would leave behind.
    always_comb begin
        w_start     = (r_state == ST_IDLE) && bus.collectData;
        w_offer     = (r_state == ST_RUN) || (r_state == ST_FLUSH);
        w_write     = w_offer && !bus.fifoFull;
        w_drop      = w_offer && bus.fifoFull;
        w_word_next = r_word_cnt + WORD_CNT_W'(w_write);
        if (r_src_sel) begin
            w_sample = r_test_cnt;
        end else begin
            w_sample = r_adc_q;
        end
    end

    // Next-state logic. Leaving RUN or FLUSH is judged on the post-write word
    // count so the final block is always complete. FLUSH ignores collectData.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.collectData) begin
                    w_state_next = ST_SETTLE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!bus.collectData) begin
                    w_state_next = ST_IDLE;
                end else if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (bus.collectData) begin
                    w_state_next = ST_RUN;
                end else if (w_word_next == {WORD_CNT_W{1'b0}}) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_word_next == {WORD_CNT_W{1'b0}}) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_FLUSH;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register with busy flag registered alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    // Settle counter: cleared on start, one count per SETTLE clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_settle_cnt <= 8'd0;
        end else if (w_start) begin
            r_settle_cnt <= 8'd0;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
        end else begin
            r_settle_cnt <= r_settle_cnt;
        end
    end

    // Block word counter: advances only on accepted writes, wraps per block.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word_cnt <= {WORD_CNT_W{1'b0}};
        end else if (w_start) begin
            r_word_cnt <= {WORD_CNT_W{1'b0}};
        end else begin
            r_word_cnt <= w_word_next;
        end
    end

    // Test pattern counter: one step per offered sample, written or dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_test_cnt <= 10'd0;
        end else if (w_start) begin
            r_test_cnt <= 10'd0;
        end else if (w_offer) begin
            r_test_cnt <= r_test_cnt + 10'd1;
        end else begin
            r_test_cnt <= r_test_cnt;
        end
    end

    // Source select is latched at start so testMode is ignored while busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src_sel <= 1'b0;
        end else if (w_start) begin
            r_src_sel <= bus.testMode;
        end else begin
            r_src_sel <= r_src_sel;
        end
    end

    // First pipeline stage for the ADC sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_adc_q <= 10'd0;
        end else begin
            r_adc_q <= bus.adcData;
        end
    end

    // Sticky overflow: cleared only on start, set by any dropped sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    // Registered output stage: strobe plus converted sample, data held otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fifo_write <= 1'b0;
            r_fifo_data  <= 16'h0000;
        end else begin
            r_fifo_write <= w_write;
            if (w_write) begin
                r_fifo_data <= f_offset_to_signed(w_sample);
            end else begin
                r_fifo_data <= r_fifo_data;
            end
        end
    end

    assign bus.fifoWrite = r_fifo_write;
    assign bus.fifoData  = r_fifo_data;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Self-checking bench for adc_capture_sequencer. Each directed step fills a
// per-cycle stimulus table (mostly $urandom data), a capture-level reference
// model predicts the written stream, busy profile and overflow, and the DUT is
// then driven from the same table and compared.
module tb_adc_capture_sequencer;

    localparam int S    = 16;
    localparam int B    = 256;
    localparam int MAXC = 4096;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    adc_capture_sequencer_if bus ();

    adc_capture_sequencer #(
        .SETTLE_CYCLES (S),
        .BLOCK_WORDS   (B)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Stimulus table
    bit          s_col  [MAXC];
    bit          s_full [MAXC];
    logic [9:0]  s_adc  [MAXC];
    bit          s_tm   [MAXC];

    // Expectations and observations
    int          exp_cyc[$];
    logic [15:0] exp_val[$];
    bit          exp_busy [MAXC];
    bit          exp_ovf;
    int          exp_end;
    int          got_cyc[$];
    logic [15:0] got_val[$];
    logic        got_busy [MAXC];
    logic [15:0] last_val;

    int n_tests;
    int n_fail;

    function automatic logic [15:0] to_s16(input logic [9:0] v);
        return 16'((int'(v) - 512) * 64);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            s_col[i]  = 1'b0;
            s_full[i] = 1'b0;
            s_adc[i]  = 10'($urandom_range(1023, 0));
            s_tm[i]   = 1'($urandom_range(1, 0));
        end
    endtask

    // Capture-level model: a capture starts on a cycle with the request high
    // while idle, throws away S clocks, then offers one sample per clock.
    // Offers continue while the request is held; once it drops, offers go on
    // until the count of accepted words is a whole number of blocks.
    task automatic model_segment();
        int c, p, k, written, endc;
        bit holding, ovf, tm, aborted;
        logic [9:0] val;
        exp_cyc.delete();
        exp_val.delete();
        for (int i = 0; i < MAXC; i++) exp_busy[i] = 1'b0;
        exp_ovf = 1'b0;
        exp_end = 0;
        c = 0;
        while (c < MAXC - S - 2) begin
            if (!s_col[c]) begin
                c++;
            end else begin
                tm = s_tm[c];
                ovf = 1'b0;
                aborted = 1'b0;
                endc = c + S;
                for (int j = 1; j <= S; j++) begin
                    if (!aborted && !s_col[c + j]) begin
                        aborted = 1'b1;
                        endc = c + j;
                    end
                end
                if (!aborted) begin
                    p = c + S + 1;
                    k = 0;
                    written = 0;
                    holding = 1'b1;
                    while (p < MAXC - 2) begin
                        val = tm ? 10'(k % 1024) : s_adc[p - 1];
                        if (!s_full[p]) begin
                            exp_cyc.push_back(p + 1);
                            exp_val.push_back(to_s16(val));
                            written++;
                        end else begin
                            ovf = 1'b1;
                        end
                        k++;
                        if (holding && !s_col[p]) holding = 1'b0;
                        if (!holding && (written % B == 0)) break;
                        p++;
                    end
                    endc = p;
                end
                for (int i = c + 1; i <= endc; i++) exp_busy[i] = 1'b1;
                exp_ovf = ovf;
                exp_end = endc;
                c = endc + 1;
            end
        end
    endtask

    // Drive n cycles from the table and compare; 'complete' means the DUT is
    // expected to be idle again by the end of the run.
    task automatic run_segment(input string tag, input int n, input bit complete);
        int n_exp, bad, f0;
        logic [15:0] hold_exp;
        got_cyc.delete();
        got_val.delete();
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            got_busy[i] = bus.busy;
            if (bus.fifoWrite === 1'b1) begin
                got_cyc.push_back(i);
                got_val.push_back(bus.fifoData);
            end
            bus.collectData = s_col[i];
            bus.fifoFull    = s_full[i];
            bus.adcData     = s_adc[i];
            bus.testMode    = s_tm[i];
        end
        n_exp = 0;
        foreach (exp_cyc[i]) if (exp_cyc[i] < n) n_exp++;
        chk({tag, "_write_count"}, 32'(got_cyc.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < got_cyc.size(); i++) begin
            f0 = n_fail;
            chk({tag, "_write_cycle_value"}, {16'(got_cyc[i]), got_val[i]},
                {16'(exp_cyc[i]), exp_val[i]});
            if (n_fail != f0) break;
        end
        bad = 0;
        for (int i = 0; i < n; i++) if (got_busy[i] !== exp_busy[i]) bad++;
        chk({tag, "_busy_profile_errors"}, 32'(bad), 32'd0);
        if (complete) begin
            hold_exp = (exp_val.size() > 0) ? exp_val[exp_val.size() - 1] : last_val;
            chk({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
            chk({tag, "_data_hold"}, 32'(bus.fifoData), 32'(hold_exp));
            chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        end
        if (exp_val.size() > 0) last_val = exp_val[exp_val.size() - 1];
    endtask

    task automatic apply_reset_and_check(input string tag);
        int writes;
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.collectData = 1'b0;
        bus.fifoFull    = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk({tag, "_fifoWrite"}, 32'(bus.fifoWrite), 32'd0);
        chk({tag, "_fifoData"},  32'(bus.fifoData),  32'h0000);
        chk({tag, "_overflow"},  32'(bus.overflow),  32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (bus.fifoWrite !== 1'b0) writes++;
        end
        chk({tag, "_quiet"}, 32'(writes), 32'd0);
        last_val = 16'h0000;
    endtask

    initial begin
        int len, gap, plen;
        n_tests  = 0;
        n_fail   = 0;
        last_val = 16'h0000;
        bus.collectData = 1'b0;
        bus.testMode    = 1'b0;
        bus.adcData     = 10'd0;
        bus.fifoFull    = 1'b0;

        // Step 1: reset values
        apply_reset_and_check("reset_init");

        // Step 2: counter source, long request, no back-pressure (5 blocks)
        clear_stim();
        s_tm[0] = 1'b1;
        for (int i = 0; i < 1200; i++) s_col[i] = 1'b1;
        model_segment();
        run_segment("tm_long", exp_end + 4, 1'b1);
        chk("tm_long_total", 32'(got_val.size()), 32'd1280);
        if (got_val.size() > 1024) begin
            chk("tm_long_first", 32'(got_val[0]), 32'h8000);
            chk("tm_long_top", 32'(got_val[1023]), 32'h7FC0);
            chk("tm_long_wrap", 32'(got_val[1024]), 32'h8000);
        end

        // Step 3: ADC source at mid-scale, short pulse flushes a full block
        clear_stim();
        s_tm[0] = 1'b0;
        for (int i = 0; i < MAXC; i++) s_adc[i] = 10'd512;
        for (int i = 0; i < 100; i++) s_col[i] = 1'b1;
        model_segment();
        run_segment("adc_mid", exp_end + 4, 1'b1);
        chk("adc_mid_total", 32'(got_val.size()), 32'd256);
        chk("adc_mid_overflow", 32'(bus.overflow), 32'd0);

        // Step 4: FIFO full for 3 clocks mid-RUN
        clear_stim();
        s_tm[0] = 1'b1;
        for (int i = 0; i < 300; i++) s_col[i] = 1'b1;
        for (int i = 100; i < 103; i++) s_full[i] = 1'b1;
        model_segment();
        run_segment("full3", exp_end + 4, 1'b1);
        chk("full3_total", 32'(got_val.size()), 32'd512);
        chk("full3_overflow", 32'(bus.overflow), 32'd1);

        // Step 5: request dropped at settle clock 5 (also clears overflow)
        clear_stim();
        for (int i = 0; i < 5; i++) s_col[i] = 1'b1;
        model_segment();
        run_segment("settle_abort", exp_end + 6, 1'b1);
        chk("settle_abort_writes", 32'(got_val.size()), 32'd0);
        chk("settle_abort_busy6", 32'(got_busy[6]), 32'd0);

        // Step 6: request toggled during FLUSH, then held across the block end
        clear_stim();
        s_tm[0] = 1'b1;
        s_tm[273] = 1'b1;
        for (int i = 0; i < 51; i++) s_col[i] = 1'b1;
        for (int i = 61; i <= 400; i++) s_col[i] = 1'b1;
        model_segment();
        run_segment("flush_toggle", exp_end + 4, 1'b1);
        chk("flush_toggle_total", 32'(got_val.size()), 32'd512);
        chk("flush_toggle_idle_gap", 32'(got_busy[273]), 32'd0);
        chk("flush_toggle_resettle", 32'(got_busy[274]), 32'd1);

        // Step 7: randomized captures with random back-pressure and re-pulses
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            len  = $urandom_range(600, 20);
            gap  = $urandom_range(400, 1);
            plen = $urandom_range(30, 1);
            for (int i = 0; i < len; i++) s_col[i] = 1'b1;
            for (int i = len + gap; i < len + gap + plen; i++) s_col[i] = 1'b1;
            for (int i = 0; i < MAXC; i++) s_full[i] = ($urandom_range(7, 0) == 0);
            model_segment();
            run_segment("random", exp_end + 4, 1'b1);
            chk("random_block_multiple", 32'(got_val.size() % B), 32'd0);
        end

        // Step 8: reset in the middle of a FLUSH abandons the block
        clear_stim();
        s_tm[0] = 1'b1;
        for (int i = 0; i < 41; i++) s_col[i] = 1'b1;
        model_segment();
        run_segment("flush_reset", 150, 1'b0);
        apply_reset_and_check("flush_reset_after");

        // Step 9: clean counter stream after that reset
        clear_stim();
        s_tm[0] = 1'b1;
        for (int i = 0; i < 30; i++) s_col[i] = 1'b1;
        model_segment();
        run_segment("post_reset", exp_end + 4, 1'b1);
        if (got_val.size() > 0) chk("post_reset_first", 32'(got_val[0]), 32'h8000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
